// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC dot-product accumulator.
// Result entries are sized from the default operand and guard widths.
package cordic_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int GUARD_DEF = 4;
    localparam int CNT_W_DEF = 8;

    function automatic int acc_w(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    localparam int ACC_W = acc_w(WIDTH_DEF, GUARD_DEF);

    typedef struct packed {
        logic signed [ACC_W-1:0] sum;
        logic [CNT_W_DEF-1:0]    cnt;
        logic                    sat;
    } dot_res_t;

    function automatic logic [ACC_W-1:0] sat_max();
        return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    function automatic logic [ACC_W-1:0] sat_min();
        return {1'b1, {(ACC_W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/cordic_res_fifo.sv
// Small synchronous FIFO of completed dot-product results.
// Pointers carry a wrap bit so occupancy is a plain subtraction.
module cordic_res_fifo
    import cordic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     aresetn_i,
    input  logic                     push_i,
    input  dot_res_t                 data_i,
    input  logic                     pop_i,
    output dot_res_t                 data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    dot_res_t    mem_q [DEPTH];
    logic        empty, full, do_push, do_pop;

    assign count_o = wptr_q - rptr_q;
    assign empty   = (count_o == '0);
    assign full    = (count_o == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);
    assign valid_o = !empty;

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(do_push);
        rptr_d = rptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define emptiness, and the
    // head is forced to zero while empty so nothing stale is ever visible.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

    assign data_o = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    push_while_full_a : assert property (
        @(posedge clk_i) disable iff (!aresetn_i) !(push_i && full && !pop_i));

endmodule

// File: rtl/cordic_dot_acc.sv
// Re-aligns valid/last with the fixed-latency multiplier output, accumulates
// saturating dot products and hands them out through a credit-gated FIFO.
module cordic_dot_acc
    import cordic_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int LATENCY    = 8,
    parameter int GUARD      = GUARD_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FIFO_DEPTH = 4,
    localparam int SUM_W     = acc_w(WIDTH, GUARD)
) (
    input  logic               clk_i,
    input  logic               aresetn_i,
    input  logic               in_valid_i,
    input  logic               in_last_i,
    output logic               in_ready_o,
    input  logic [2*WIDTH-1:0] prod_i,
    output logic [SUM_W-1:0]   sum_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               sat_o,
    output logic               sum_valid_o,
    input  logic               sum_ready_i
);

    localparam int FC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CR_W = $clog2(FIFO_DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] dl_valid_q, dl_valid_d;
    logic [LATENCY-1:0] dl_last_q, dl_last_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               first_q, first_d;

    logic               accept, tap_valid, tap_last, push, ovf;
    logic [CR_W-1:0]    lasts, credits;
    logic [FC_W-1:0]    fifo_count;
    logic [SUM_W-1:0]   base, prod_ext, acc_next;
    logic [SUM_W:0]     sum_wide;
    logic [CNT_W-1:0]   cnt_base, cnt_next;
    logic               sat_next;
    dot_res_t           push_data, head;

    assign accept    = in_valid_i && in_ready_o;
    assign tap_valid = dl_valid_q[LATENCY-1];
    assign tap_last  = dl_last_q[LATENCY-1];
    assign push      = tap_valid && tap_last;

    // Every in-flight last beat has a FIFO slot reserved for it.
    always_comb begin
        lasts = '0;
        for (int i = 0; i < LATENCY; i++) begin
            lasts = lasts + CR_W'(dl_valid_q[i] & dl_last_q[i]);
        end
        credits    = CR_W'(FIFO_DEPTH) - CR_W'(fifo_count) - lasts;
        in_ready_o = (credits != '0);
    end

    always_comb begin
        base     = first_q ? '0 : acc_q;
        prod_ext = {{GUARD{prod_i[2*WIDTH-1]}}, prod_i};
        sum_wide = {base[SUM_W-1], base} + {prod_ext[SUM_W-1], prod_ext};
        ovf      = (sum_wide[SUM_W] != sum_wide[SUM_W-1]);
        if (!ovf)                acc_next = sum_wide[SUM_W-1:0];
        else if (sum_wide[SUM_W]) acc_next = sat_min();
        else                     acc_next = sat_max();
        cnt_base = first_q ? '0 : cnt_q;
        cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
        sat_next = (first_q ? 1'b0 : sat_q) | ovf;
    end

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        dl_valid_d = {dl_valid_q[LATENCY-2:0], accept};
        dl_last_d  = {dl_last_q[LATENCY-2:0], in_last_i};
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        first_d    = first_q;
        if (tap_valid) begin
            if (tap_last) begin
                acc_d   = '0;
                cnt_d   = '0;
                sat_d   = 1'b0;
                first_d = 1'b1;
            end else begin
                acc_d   = acc_next;
                cnt_d   = cnt_next;
                sat_d   = sat_next;
                first_d = 1'b0;
            end
        end
    end

    always_comb begin
        push_data     = '0;
        push_data.sum = acc_next;
        push_data.cnt = cnt_next;
        push_data.sat = sat_next;
    end

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            dl_valid_q <= '0;
            dl_last_q  <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            dl_valid_q <= dl_valid_d;
            dl_last_q  <= dl_last_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            first_q    <= first_d;
        end
    end

    cordic_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .aresetn_i (aresetn_i),
        .push_i    (push),
        .data_i    (push_data),
        .pop_i     (sum_ready_i),
        .data_o    (head),
        .valid_o   (sum_valid_o),
        .count_o   (fifo_count)
    );

    assign sum_o   = head.sum;
    assign count_o = head.cnt;
    assign sat_o   = head.sat;

endmodule

// File: tb/tb_cordic_dot_acc.sv
// Directed bench for cordic_dot_acc: models the multiplier as an 8-cycle
// delay and checks results against a scoreboard of expected dot products.
module tb_cordic_dot_acc;
    import cordic_pkg::*;

    localparam int LAT = 8;
    localparam longint SMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (ACC_W - 1));

    logic             clk_i = 1'b0;
    logic             aresetn_i;
    logic             in_valid_i, in_last_i, in_ready_o;
    logic [15:0]      prod_i;
    logic [ACC_W-1:0] sum_o;
    logic [7:0]       count_o;
    logic             sat_o, sum_valid_o, sum_ready_i;

    logic [15:0]      cur_prod;
    logic [15:0]      mul_pipe [LAT];

    dot_res_t         exp_q [$];
    longint           m_acc;
    int               m_cnt;
    bit               m_sat;

    int               n_checks = 0;
    int               n_fail   = 0;
    bit               stall_q  = 1'b0;
    logic [ACC_W+8:0] held;

    cordic_dot_acc dut (
        .clk_i       (clk_i),
        .aresetn_i   (aresetn_i),
        .in_valid_i  (in_valid_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .prod_i      (prod_i),
        .sum_o       (sum_o),
        .count_o     (count_o),
        .sat_o       (sat_o),
        .sum_valid_o (sum_valid_o),
        .sum_ready_i (sum_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Multiplier stand-in: accepted products emerge LAT cycles later, junk otherwise.
    always @(posedge clk_i) begin
        for (int i = LAT - 1; i > 0; i--) mul_pipe[i] <= mul_pipe[i-1];
        mul_pipe[0] <= (in_valid_i && in_ready_o) ? cur_prod : 16'($urandom);
    end
    assign prod_i = mul_pipe[LAT-1];

    task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_sat = 1'b0;
    endtask

    task automatic model_beat(input int p, input bit last);
        dot_res_t r;
        m_acc = m_acc + p;
        if (m_acc > SMAX) begin m_acc = SMAX; m_sat = 1'b1; end
        if (m_acc < SMIN) begin m_acc = SMIN; m_sat = 1'b1; end
        if (m_cnt < 255) m_cnt++;
        if (last) begin
            r.sum = ACC_W'(m_acc);
            r.cnt = 8'(m_cnt);
            r.sat = m_sat;
            exp_q.push_back(r);
            model_clear();
        end
    endtask

    // Called at a falling edge; holds the beat until accepted or the budget runs out.
    task automatic send(input int p, input bit last, input int budget = 20);
        int n = 0;
        in_valid_i = 1'b1;
        in_last_i  = last;
        cur_prod   = 16'(p);
        while (!in_ready_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check("beat_accepted", ACC_W'(in_ready_o), ACC_W'(1));
        if (in_ready_o) model_beat(p, last);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || sum_valid_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_pending", ACC_W'(exp_q.size()), ACC_W'(0));
    endtask

    // Output monitor: sampled mid-low-phase, after the stimulus has settled.
    always begin
        dot_res_t r;
        @(negedge clk_i);
        #2;
        if (!aresetn_i) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && sum_valid_o)
                check("hold_stable", ACC_W'({sum_o, count_o, sat_o} != held), ACC_W'(0));
            if (sum_valid_o && sum_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", ACC_W'(sum_valid_o), ACC_W'(0));
                end else begin
                    r = exp_q.pop_front();
                    check("sum", sum_o, r.sum);
                    check("count", ACC_W'(count_o), ACC_W'(r.cnt));
                    check("sat", ACC_W'(sat_o), ACC_W'(r.sat));
                end
            end
            stall_q = sum_valid_o && !sum_ready_i;
            held    = {sum_o, count_o, sat_o};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        aresetn_i   = 1'b0;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        sum_ready_i = 1'b0;
        cur_prod    = '0;
        model_clear();
        repeat (3) @(negedge clk_i);
        check("rst_in_ready", ACC_W'(in_ready_o), ACC_W'(1));
        check("rst_sum_valid", ACC_W'(sum_valid_o), ACC_W'(0));
        check("rst_sum", sum_o, ACC_W'(0));
        check("rst_count", ACC_W'(count_o), ACC_W'(0));
        check("rst_sat", ACC_W'(sat_o), ACC_W'(0));
        aresetn_i = 1'b1;
        @(negedge clk_i);

        // Three-term vector: result appears LATENCY+1 cycles after the last accept.
        sum_ready_i = 1'b1;
        send(2 * 5, 1'b0);
        send(4 * 5, 1'b0);
        send(-1 * 5, 1'b1);
        repeat (LAT - 1) @(negedge clk_i);
        check("t1_not_early", ACC_W'(sum_valid_o), ACC_W'(0));
        @(negedge clk_i);
        check("t1_valid", ACC_W'(sum_valid_o), ACC_W'(1));
        check("t1_sum", sum_o, ACC_W'(25));
        check("t1_count", ACC_W'(count_o), ACC_W'(3));
        wait_drain();

        // Back-to-back single-beat vectors leave on consecutive cycles.
        send(3 * 3, 1'b1);
        send(-7 * 2, 1'b1);
        repeat (LAT - 1) @(negedge clk_i);
        check("t2_first", sum_o, ACC_W'(9));
        @(negedge clk_i);
        check("t2_second", sum_o, ACC_W'(-14));
        check("t2_second_cnt", ACC_W'(count_o), ACC_W'(1));
        wait_drain();

        // Saturation, then a clean vector proving the sticky flag restarts.
        for (int i = 0; i < 16; i++) send(32767, 1'b0);
        send(32767, 1'b1);
        send(1, 1'b1);
        wait_drain();

        // Backpressure: four credits, then stall until the consumer drains.
        sum_ready_i = 1'b0;
        for (int v = 1; v <= 4; v++) send(v, 1'b1);
        check("bp_ready_low", ACC_W'(in_ready_o), ACC_W'(0));
        in_valid_i = 1'b1;
        in_last_i  = 1'b1;
        cur_prod   = 16'd5;
        repeat (12) @(negedge clk_i);
        check("bp_still_blocked", ACC_W'(in_ready_o), ACC_W'(0));
        check("bp_head", sum_o, ACC_W'(1));
        sum_ready_i = 1'b1;
        send(5, 1'b1, 30);
        send(6, 1'b1, 30);
        wait_drain();

        // Reset with one buffered result and a partial vector in flight.
        sum_ready_i = 1'b0;
        send(7, 1'b1);
        n = 0;
        while (!sum_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("mid_pending", ACC_W'(sum_valid_o), ACC_W'(1));
        send(3, 1'b0);
        send(3, 1'b0);
        @(negedge clk_i);
        aresetn_i = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        check("mid_rst_in_ready", ACC_W'(in_ready_o), ACC_W'(1));
        check("mid_rst_valid", ACC_W'(sum_valid_o), ACC_W'(0));
        check("mid_rst_sum", sum_o, ACC_W'(0));
        check("mid_rst_count", ACC_W'(count_o), ACC_W'(0));
        check("mid_rst_sat", ACC_W'(sat_o), ACC_W'(0));
        @(negedge clk_i);
        aresetn_i = 1'b1;
        @(negedge clk_i);
        sum_ready_i = 1'b1;
        send(4, 1'b1);
        wait_drain();

        // Idle cycles between beats must not disturb the sum or count.
        send(3 * 4, 1'b0);
        repeat (2) @(negedge clk_i);
        send(-2 * 7, 1'b0);
        repeat (2) @(negedge clk_i);
        send(9 * 9, 1'b1);
        wait_drain();

        repeat (4) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
